// File: rtl/otbn_job_arbiter.sv
// Two-requester round-robin job arbiter for a single accelerator: grants a job,
// pulses start, tracks ack/run/timeout, and returns a cycle count to the owner.
module otbn_job_arbiter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000000,
    parameter int ACK_MAX = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [CNT_W-1:0] resp_cycles,
    output logic             resp_timeout,
    input  logic             status_idle,
    output logic             start_cmd,
    input  logic             done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ACK_MAX_C = CNT_W'(ACK_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_RUN,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             gnt;
    logic [1:0]       req_ready_c;

    // Saturating increment: the counter sticks at its maximum instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        req_ready_c = 2'b00;
        gnt         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (status_idle && (|req_valid)) begin
                    gnt              = req_valid[prio_q] ? prio_q : ~prio_q;
                    req_ready_c[gnt] = 1'b1;
                    owner_d          = gnt;
                    prio_d           = ~gnt;
                    state_d          = S_START;
                end
            end
            S_START: begin
                cnt_d   = CNT_ONE;
                to_d    = 1'b0;
                state_d = S_ACK;
            end
            // done is deliberately not looked at here: it may still be high from the previous job.
            S_ACK: begin
                if (!status_idle) begin
                    cnt_d   = cnt_inc;
                    state_d = S_RUN;
                end else if (cnt_q >= ACK_MAX_C) begin
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN: begin
                if (done) begin
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q >= TIMEOUT_C) begin
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                if (resp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    assign req_ready    = req_ready_c;
    assign resp_valid   = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_cycles  = cnt_q;
    assign resp_timeout = to_q;
    assign start_cmd    = (state_q == S_START);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_otbn_job_arbiter.sv
// Directed bench for otbn_job_arbiter: a per-cycle vector table for one job,
// then hand-written sequences for contention, ack/run timeouts, stale done and reset.
module tb_otbn_job_arbiter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;
    localparam int ACK_MAX = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [CNT_W-1:0] resp_cycles;
    logic             resp_timeout;
    logic             status_idle;
    logic             start_cmd;
    logic             done;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;

    otbn_job_arbiter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .ACK_MAX(ACK_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_cycles (resp_cycles),
        .resp_timeout(resp_timeout),
        .status_idle (status_idle),
        .start_cmd   (start_cmd),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start_cmd === 1'b1) starts++;

    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic [1:0]  rr;
        logic        idle;
        logic        dn;
        logic [1:0]  e_rdy;
        logic [1:0]  e_rv;
        logic        e_start;
        logic        e_busy;
        logic [31:0] e_cyc;
        logic        e_to;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic r, input logic [1:0] rv, input logic [1:0] rr,
                                input logic idle, input logic dn, input logic [1:0] e_rdy,
                                input logic [1:0] e_rv, input logic e_start, input logic e_busy,
                                input logic [31:0] e_cyc, input logic e_to);
        vec_t v;
        v.rst = r; v.rv = rv; v.rr = rr; v.idle = idle; v.dn = dn;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_start = e_start; v.e_busy = e_busy;
        v.e_cyc = e_cyc; v.e_to = e_to;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge; outputs are checked 1ns later.
    task automatic drive(input logic r, input logic [1:0] rv, input logic [1:0] rr,
                         input logic idle, input logic dn);
        @(negedge clk);
        reset = r; req_valid = rv; resp_ready = rr; status_idle = idle; done = dn;
        #1;
    endtask

    task automatic do_job(input logic [1:0] rv, input logic [1:0] g, input int run_len,
                          input string nm);
        drive(0, rv, 2'b00, 1, 0);
        chk({nm, "_grant"}, 32'(req_ready), 32'(g));
        drive(0, rv, 2'b00, 1, 0);
        chk({nm, "_start"}, 32'(start_cmd), 32'd1);
        chk({nm, "_wait_start"}, 32'(req_ready), 32'd0);
        drive(0, rv, 2'b00, 0, 0);
        for (int i = 0; i < run_len; i++) begin
            drive(0, rv, 2'b00, 0, 0);
            chk({nm, "_wait_run"}, 32'(req_ready), 32'd0);
        end
        drive(0, rv, 2'b00, 0, 1);
        drive(0, rv, g, 1, 0);
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'(g));
        chk({nm, "_resp_cycles"}, 32'(resp_cycles), 32'(run_len + 2));
        chk({nm, "_resp_timeout"}, 32'(resp_timeout), 32'd0);
        chk({nm, "_wait_resp"}, 32'(req_ready), 32'd0);
        $display("job %s: owner=%b cycles=%0d timeout=%0b", nm, resp_valid, resp_cycles, resp_timeout);
    endtask

    initial begin
        int s0;
        bit seen;
        reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00; status_idle = 1'b1; done = 1'b0;

        // Single job: idle drops 2 cycles after start, done 10 cycles after that.
        tbl[0]  = mk(1, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0);
        tbl[2]  = mk(0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0);
        tbl[3]  = mk(0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 0, 1, 1, 0);
        tbl[4]  = mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 2, 0);
        for (int k = 3; k <= 11; k++)
            tbl[k + 2] = mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 32'(k), 0);
        tbl[14] = mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1, 12, 0);
        tbl[15] = mk(0, 2'b00, 2'b10, 1, 0, 2'b00, 2'b01, 0, 1, 12, 0);
        tbl[16] = mk(0, 2'b00, 2'b01, 1, 0, 2'b00, 2'b01, 0, 1, 12, 0);
        tbl[17] = mk(0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 12, 0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rr, tbl[i].idle, tbl[i].dn);
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_resp_valid", i), 32'(resp_valid), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d_start_cmd", i), 32'(start_cmd), 32'(tbl[i].e_start));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_resp_cycles", i), 32'(resp_cycles), tbl[i].e_cyc);
            chk($sformatf("vec%0d_resp_timeout", i), 32'(resp_timeout), 32'(tbl[i].e_to));
        end
        $display("job table: single job done, starts=%0d", starts);

        // Contention from a fresh reset: requester 0 first, then 1.
        drive(1, 2'b00, 2'b00, 1, 0);
        s0 = starts;
        do_job(2'b11, 2'b01, 3, "cont0");
        do_job(2'b11, 2'b10, 5, "cont1");
        chk("cont_start_pulses", 32'(starts - s0), 32'd2);

        // No ack: accelerator never leaves idle.
        drive(0, 2'b01, 2'b00, 1, 0);
        chk("noack_grant", 32'(req_ready), 32'b01);
        drive(0, 2'b00, 2'b00, 1, 0);
        for (int i = 0; i < ACK_MAX; i++) begin
            drive(0, 2'b00, 2'b00, 1, 0);
            chk("noack_no_resp_yet", 32'(resp_valid), 32'd0);
        end
        drive(0, 2'b00, 2'b01, 1, 0);
        chk("noack_resp_valid", 32'(resp_valid), 32'b01);
        chk("noack_timeout", 32'(resp_timeout), 32'd1);
        chk("noack_cycles", 32'(resp_cycles), 32'(ACK_MAX));
        $display("job noack: owner=%b cycles=%0d timeout=%0b", resp_valid, resp_cycles, resp_timeout);
        drive(0, 2'b00, 2'b00, 1, 0);
        chk("noack_back_idle", 32'(busy), 32'd0);

        // Run timeout: done never arrives.
        drive(0, 2'b10, 2'b00, 1, 0);
        chk("tmo_grant", 32'(req_ready), 32'b10);
        drive(0, 2'b00, 2'b00, 1, 0);
        drive(0, 2'b00, 2'b00, 0, 0);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            drive(0, 2'b00, 2'b00, 0, 0);
            if (resp_valid != 2'b00) seen = 1'b1;
        end
        chk("tmo_resp_seen", 32'(seen), 32'd1);
        chk("tmo_resp_valid", 32'(resp_valid), 32'b10);
        chk("tmo_timeout", 32'(resp_timeout), 32'd1);
        chk("tmo_cycles", 32'(resp_cycles), 32'(TIMEOUT));
        $display("job timeout: owner=%b cycles=%0d timeout=%0b", resp_valid, resp_cycles, resp_timeout);
        drive(0, 2'b00, 2'b10, 1, 0);
        drive(0, 2'b00, 2'b00, 1, 0);
        chk("tmo_back_idle", 32'(busy), 32'd0);

        // Stale done held through START/ACK must not complete the job.
        drive(0, 2'b01, 2'b00, 1, 1);
        chk("stale_grant", 32'(req_ready), 32'b01);
        drive(0, 2'b00, 2'b00, 1, 1);
        chk("stale_start", 32'(start_cmd), 32'd1);
        drive(0, 2'b00, 2'b00, 1, 1);
        chk("stale_ack1", 32'(resp_valid), 32'd0);
        drive(0, 2'b00, 2'b00, 1, 1);
        chk("stale_ack2", 32'(resp_valid), 32'd0);
        drive(0, 2'b00, 2'b00, 0, 1);
        chk("stale_ack3", 32'(resp_valid), 32'd0);
        drive(0, 2'b00, 2'b00, 0, 1);
        chk("stale_run", 32'(resp_valid), 32'd0);
        drive(0, 2'b00, 2'b01, 1, 0);
        chk("stale_resp_valid", 32'(resp_valid), 32'b01);
        chk("stale_cycles", 32'(resp_cycles), 32'd4);
        chk("stale_timeout", 32'(resp_timeout), 32'd0);
        $display("job stale: owner=%b cycles=%0d timeout=%0b", resp_valid, resp_cycles, resp_timeout);

        // Reset mid-RUN abandons the job; pointer returns to requester 0.
        drive(0, 2'b11, 2'b00, 1, 0);
        chk("rst_grant", 32'(req_ready), 32'b10);
        drive(0, 2'b00, 2'b00, 1, 0);
        drive(0, 2'b00, 2'b00, 0, 0);
        drive(0, 2'b00, 2'b00, 0, 0);
        drive(0, 2'b00, 2'b00, 0, 0);
        s0 = starts;
        drive(1, 2'b11, 2'b11, 0, 1);
        drive(0, 2'b00, 2'b00, 1, 0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_start", 32'(start_cmd), 32'd0);
        chk("rst_cycles", 32'(resp_cycles), 32'd0);
        chk("rst_timeout", 32'(resp_timeout), 32'd0);
        chk("rst_no_restart", 32'(starts - s0), 32'd0);
        drive(0, 2'b11, 2'b00, 1, 0);
        chk("rst_next_grant", 32'(req_ready), 32'b01);
        $display("job reset: abandoned, next grant=%b", req_ready);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
